// File: rtl/key_seq_player.sv
// Plays a packed 4-key sequence on the arrow display, one key per dwell period, then pulses play_done.
// Define KEYPLAY_GAP_EN to insert a blank gap of GAP_CYCLES after every shown key.
module key_seq_player #(
  parameter int DWELL_CYCLES = 25_000_000,
  parameter int GAP_CYCLES   = 5_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] key_seq,
  output logic [3:0]  disp_key,
  output logic        disp_valid,
  output logic [1:0]  key_index,
  output logic        busy,
  output logic        play_done
);

  localparam int MAX_CYC = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] DWELL_LD = TW'(DWELL_CYCLES);
`ifdef KEYPLAY_GAP_EN
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
`ifdef KEYPLAY_GAP_EN
    GAP  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [15:0]     r_seq;
  logic [1:0]      r_idx;
  logic [TW-1:0]   r_timer;
  logic [1:0]      w_idx_inc;
  logic [3:0]      w_nib_cur;
  logic [3:0]      w_nib_next;
  logic            w_expired;
  logic            w_last;
  logic            w_accept;

  function automatic logic [3:0] sel_nib(input logic [15:0] s, input logic [1:0] i);
    case (i)
      2'd0:    return s[15:12];
      2'd1:    return s[11:8];
      2'd2:    return s[7:4];
      default: return s[3:0];
    endcase
  endfunction

  assign w_idx_inc  = r_idx + 2'd1;
  assign w_nib_cur  = sel_nib(r_seq, r_idx);
  assign w_nib_next = sel_nib(r_seq, w_idx_inc);
  assign w_expired  = (r_timer == TW'(1));
  // Playback ends after slot 3 or when the following slot holds the terminator.
  assign w_last     = (r_idx == 2'd3) || (w_nib_next == 4'hF);
  assign w_accept   = start && !abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = (key_seq[15:12] == 4'hF) ? DONE : SHOW;
      SHOW: begin
        if (abort) w_state_nxt = IDLE;
        else if (w_expired) begin
`ifdef KEYPLAY_GAP_EN
          w_state_nxt = GAP;
`else
          w_state_nxt = w_last ? DONE : SHOW;
`endif
        end
      end
`ifdef KEYPLAY_GAP_EN
      GAP: begin
        if (abort) w_state_nxt = IDLE;
        else if (w_expired) w_state_nxt = w_last ? DONE : SHOW;
      end
`endif
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seq   <= '0;
      r_idx   <= '0;
      r_timer <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_seq   <= key_seq;
          r_idx   <= '0;
          r_timer <= DWELL_LD;
        end
        SHOW: begin
          if (w_expired) begin
`ifdef KEYPLAY_GAP_EN
            r_timer <= GAP_LD;
`else
            if (!w_last) r_idx <= w_idx_inc;
            r_timer <= DWELL_LD;
`endif
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
`ifdef KEYPLAY_GAP_EN
        GAP: begin
          if (w_expired) begin
            if (!w_last) r_idx <= w_idx_inc;
            r_timer <= DWELL_LD;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    disp_key   = 4'h0;
    disp_valid = 1'b0;
    key_index  = r_idx;
    busy       = (r_state != IDLE);
    play_done  = (r_state == DONE);
    if (r_state == SHOW) begin
      disp_key   = w_nib_cur;
      disp_valid = 1'b1;
    end
  end

endmodule

// File: tb/tb_key_seq_player.sv
// Bench for key_seq_player: table vectors, directed corner cases and random sequences against a timeline model.
module tb_key_seq_player;

  localparam int D = 4;
  localparam int G = 2;
`ifdef KEYPLAY_GAP_EN
  localparam int P = D + G;
`else
  localparam int P = D;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] key_seq = 16'h0;
  logic [3:0]  disp_key;
  logic        disp_valid;
  logic [1:0]  key_index;
  logic        busy;
  logic        play_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] seq;
    int          exp_n;
  } vec_t;
  vec_t vecs[7];

  key_seq_player #(.DWELL_CYCLES(D), .GAP_CYCLES(G)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .key_seq(key_seq),
    .disp_key(disp_key), .disp_valid(disp_valid), .key_index(key_index),
    .busy(busy), .play_done(play_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input int t, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%h required=%h", name, t, got, exp);
    end
  endtask

  function automatic logic [3:0] nib(input logic [15:0] s, input int k);
    return 4'((s >> (12 - 4 * k)) & 16'h000F);
  endfunction

  function automatic int count_keys(input logic [15:0] s);
    int n = 0;
    while (n < 4 && nib(s, n) != 4'hF) n++;
    return n;
  endfunction

  // Expected outputs at cycle offset t after the accepted start; ab = first cycle forced idle by abort.
  task automatic model(input logic [15:0] s, input int t, input int ab,
                       output logic [3:0] k, output logic v, output logic [1:0] ix,
                       output logic b, output logic d);
    int n;
    n = count_keys(s);
    k = 4'h0; v = 1'b0; ix = 2'd0; b = 1'b0; d = 1'b0;
    if (ab >= 0 && t >= ab) return;
    if (t < n * P) begin
      b = 1'b1;
      if ((t % P) < D) begin
        v  = 1'b1;
        ix = 2'(t / P);
        k  = nib(s, t / P);
      end
    end else if (t == n * P) begin
      b = 1'b1;
      d = 1'b1;
    end
  endtask

  // Runs one playback; ab/sb/chg are cycle offsets for abort, busy-start and key_seq change (-1 = none).
  task automatic play(input logic [15:0] sq, input int ab, input int sb, input int chg, input int exp_done);
    int n, last, done_t;
    logic [3:0] ek;
    logic [1:0] ei;
    logic ev, eb, ed;
    n = count_keys(sq);
    last = n * P + 2;
    done_t = -1;
    key_seq = sq;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t <= last; t++) begin
      model(sq, t, ab, ek, ev, ei, eb, ed);
      chk("disp_key", t, 16'(disp_key), 16'(ek));
      chk("disp_valid", t, 16'(disp_valid), 16'(ev));
      chk("busy", t, 16'(busy), 16'(eb));
      chk("play_done", t, 16'(play_done), 16'(ed));
      if (ev) chk("key_index", t, 16'(key_index), 16'(ei));
      if (play_done && done_t < 0) done_t = t;
      abort = (t + 1 == ab);
      start = (t + 1 == sb);
      if (t + 1 == sb || t + 1 == chg) key_seq = 16'($urandom);
      @(posedge clk); #1;
    end
    abort = 1'b0;
    start = 1'b0;
    if (exp_done != -2) chk("done_cycle", 0, 16'(done_t), 16'(exp_done));
  endtask

  initial begin
    int ab, n;
    logic [15:0] s;
    logic [3:0] nb;

    vecs[0] = '{16'h32FF, 2};
    vecs[1] = '{16'h4221, 4};
    vecs[2] = '{16'hFFFF, 0};
    vecs[3] = '{16'h11FF, 2};
    vecs[4] = '{16'h0F00, 1};
    vecs[5] = '{16'h7F12, 1};
    vecs[6] = '{16'h0000, 4};

    // Reset state
    #12;
    chk("rst_disp_key", -1, 16'(disp_key), 16'h0);
    chk("rst_disp_valid", -1, 16'(disp_valid), 16'h0);
    chk("rst_key_index", -1, 16'(key_index), 16'h0);
    chk("rst_busy", -1, 16'(busy), 16'h0);
    chk("rst_play_done", -1, 16'(play_done), 16'h0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      play(vecs[i].seq, -1, -1, -1, vecs[i].exp_n * P);
      @(posedge clk); #1;
    end

    // Capture isolation, busy start ignored, abort mid-play
    play(16'h4221, -1, -1, 5, 4 * P);
    play(16'h11FF, -1, 3, -1, 2 * P);
    play(16'h4221, 6, -1, -1, -1);

    // start together with abort in IDLE is ignored
    key_seq = 16'h1234; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int t = 0; t < 3; t++) begin
      chk("start_abort_busy", t, 16'(busy), 16'h0);
      chk("start_abort_valid", t, 16'(disp_valid), 16'h0);
      @(posedge clk); #1;
    end

    // Asynchronous reset while a key is shown
    key_seq = 16'h4221; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_valid", 2, 16'(disp_valid), 16'h1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("areset_disp_key", -1, 16'(disp_key), 16'h0);
    chk("areset_disp_valid", -1, 16'(disp_valid), 16'h0);
    chk("areset_key_index", -1, 16'(key_index), 16'h0);
    chk("areset_busy", -1, 16'(busy), 16'h0);
    chk("areset_play_done", -1, 16'(play_done), 16'h0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_busy", 0, 16'(busy), 16'h0);

    // Random sequences with occasional aborts
    for (int r = 0; r < 25; r++) begin
      s = 16'h0;
      for (int k = 0; k < 4; k++) begin
        nb = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
        s = {s[11:0], nb};
      end
      n = count_keys(s);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, n * P + 1)) : -1;
      play(s, ab, -1, ($urandom_range(0, 1) == 0) ? 2 : -1, -2);
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
